microcode_loader: RTL and testbench
===================================

// Module: microcode_loader
// PURPOSE
//  Writes the microcode store that the control unit reads. Accepts a byte stream (valid/ready),
//  packs each 8 bytes big-endian into one 64-bit microword, writes it at an incrementing address.
//  Holds the CPU in reset (cpu_hold) while loading. Replaces file-based ROM init for synthesis/boot.
// PARAMETERS
//  DATA_W   64  microword width; must equal 8*WORD_BYTES
//  WORD_BYTES 8 bytes per microword
//  ADDR_W   12  store address width; depth = 2**ADDR_W (4096)
// PORTS
//  clk        in   1       system clock; all logic on posedge clk
//  r          in   1       reset, synchronous, active-high
//  start      in   1       begin a load (pulse); ignored in LOAD/WRITE
//  byte_valid in   1       byte_data valid
//  byte_data  in   8       stream byte
//  byte_last  in   1       qualifies final byte of image (with byte_valid)
//  byte_ready out  1       loader accepts a byte this cycle
//  wr_en      out  1       one-cycle microcode store write strobe
//  wr_addr    out  ADDR_W  store address for wr_en
//  wr_data    out  DATA_W  microword for wr_en
//  cpu_hold   out  1       drive into CPU/control-unit reset while loading
//  busy       out  1       state is LOAD, WRITE (or CSUM)
//  done       out  1       image loaded OK; held until next start or r
//  error      out  1       load failed; held until next start or r
//  words      out  ADDR_W+1 number of microwords written by last load
// BEHAVIOUR
//  Reset: state=IDLE; byte_ready, wr_en, busy, done, error, cpu_hold = 0; wr_addr, wr_data, words = 0;
//   byte counter and checksum cleared. r mid-load aborts: no further wr_en, no done/error.
//  States: IDLE, LOAD, WRITE, [CSUM], DONE, ERR.
//  IDLE/DONE/ERR --start--> LOAD: byte cnt=0, wr_addr=0, words=0, done=error=0.
//  LOAD: byte_ready=1. Byte accepted when byte_valid&&byte_ready; shifted in MSB-first
//   (first byte -> [63:56], eighth -> [7:0]). cnt 0..7.
//   - accept at cnt==7 -> WRITE (latch byte_last as last_q).
//   - byte_last at cnt!=7 -> ERR (partial word, no write).
//   - accept when words == 2**ADDR_W (store full) -> ERR.
//  WRITE (exactly 1 cycle): wr_en=1, wr_data=packed word, wr_addr=current; byte_ready=0.
//   Next: wr_addr+1 (wraps only in value; overflow caught above), words+1, cnt=0;
//   last_q ? (CSUM if enabled else DONE) : LOAD.
//  Latency: wr_en one cycle after 8th byte accepted; max throughput 8 bytes per 9 cycles.
//  cpu_hold = busy || (state==IDLE after r) ; deasserts first cycle in DONE. Stays high in ERR.
//  Empty image impossible: byte_last on first byte -> ERR.
//  start coincident with byte_valid in IDLE: byte not accepted that cycle (byte_ready=0).
//  Bit 63 of each word (end-of-microsequence flag) is written as-is; loader does not interpret it.
// CONFIGURATION
//  MICROCODE_LOADER_CHECKSUM_EN defined: running 8-bit sum of all image bytes; after the final
//   word, state CSUM accepts one trailing byte; (sum + byte)==8'h00 -> DONE, else ERR.
//   byte_last on that trailing byte is ignored.
//  Undefined: no CSUM state, no sum register; WRITE with last_q goes straight to DONE.
// STRUCTURE
//  microcode_pkg: typedef enum logic [2:0] mcl_state_t; localparams MC_WORD_BYTES=8,
//   MC_ADDR_W=12, MC_DATA_W=64, MC_END_BIT=63 (shared with control unit).
//  Sub-module mcl_word_packer: shift register + byte counter, outputs word and word_full.
//  Top holds FSM, address/word counters, checksum.
// TESTING
//  1 word: start, bytes 01..08 last on 08 -> wr_en once, addr 0, data 64'h0102030405060708, done=1, words=1.
//  3 words with byte_valid gapped every other cycle -> writes at addr 0,1,2, order intact, cpu_hold low only after done.
//  byte_last on 5th byte -> error=1, no wr_en, cpu_hold stays 1; start then clean 1-word load -> done=1, error=0.
//  4097 words without last -> 4096 writes (addr 0..4095) then error on next byte accepted.
//  r asserted after 4th byte of 2nd word -> all outputs reset next cycle, no further wr_en.
//  CHECKSUM_EN: bytes 01..08 + 8'hDC -> done; trailing 8'h00 -> error.

Source files
------------

// File: rtl/microcode_loader_pkg.sv
// Shared microcode store definitions: loader state encoding and store geometry,
// also used by the control unit that reads the store.
package microcode_pkg;

    localparam int MC_WORD_BYTES = 8;
    localparam int MC_ADDR_W     = 12;
    localparam int MC_DATA_W     = 64;
    localparam int MC_END_BIT    = 63;

    typedef enum logic [2:0] {
        MCL_IDLE  = 3'd0,
        MCL_LOAD  = 3'd1,
        MCL_WRITE = 3'd2,
        MCL_CSUM  = 3'd3,
        MCL_DONE  = 3'd4,
        MCL_ERR   = 3'd5
    } mcl_state_t;

endpackage

// File: rtl/microcode_loader_if.sv
// Byte-stream input and microcode-store write bus of the loader.
// slave = loader side, master = stream source / store side.
interface microcode_loader_if
    import microcode_pkg::*;
#(
    parameter int DATA_W = MC_DATA_W,
    parameter int ADDR_W = MC_ADDR_W
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_last;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output byte_valid, byte_data, byte_last,
        input  byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  byte_valid, byte_data, byte_last,
        output byte_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/microcode_loader_packer.sv
// mcl_word_packer: MSB-first byte shift register with a byte counter; word_full_o flags
// that the next shifted byte completes the microword.
module mcl_word_packer
    import microcode_pkg::*;
#(
    parameter int DATA_W     = MC_DATA_W,
    parameter int WORD_BYTES = MC_WORD_BYTES
) (
    input  logic              clk,
    input  logic              r,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_full_o
);
    localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] word_q;

    assign word_full_o = (cnt_q == CNT_W'(WORD_BYTES - 1));
    assign word_o      = word_q;

    always_ff @(posedge clk) begin
        if (r) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            if (clear_i) begin
                cnt_q <= '0;
            end else if (shift_i) begin
                cnt_q <= word_full_o ? '0 : cnt_q + 1'b1;
            end
            // Eight shifts overwrite every bit, so the register needs no clear between words.
            if (shift_i) begin
                word_q <= {word_q[DATA_W-9:0], byte_i};
            end
        end
    end
endmodule

// File: rtl/microcode_loader.sv
// microcode_loader: packs a big-endian byte stream into microwords written to the microcode
// store at incrementing addresses, holding the CPU in reset meanwhile. Option: MICROCODE_LOADER_CHECKSUM_EN.
module microcode_loader
    import microcode_pkg::*;
#(
    parameter int DATA_W     = MC_DATA_W,
    parameter int WORD_BYTES = MC_WORD_BYTES,
    parameter int ADDR_W     = MC_ADDR_W
) (
    input  logic              clk,
    input  logic              r,
    microcode_loader_if.slave bus,
    input  logic              start,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words
);
    localparam logic [ADDR_W:0] FULL_WORDS = {1'b1, {ADDR_W{1'b0}}};

    mcl_state_t        state_q, state_d;
    logic              byte_ready_q, wr_en_q, busy_q, done_q, error_q, cpu_hold_q, last_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W:0]   words_q;
    logic              accept, load_accept, start_load, store_full, word_full;
    logic [DATA_W-1:0] word;

    assign accept      = bus.byte_valid && byte_ready_q;
    assign load_accept = accept && (state_q == MCL_LOAD);
    assign start_load  = start && ((state_q == MCL_IDLE) || (state_q == MCL_DONE) || (state_q == MCL_ERR));
    assign store_full  = (words_q == FULL_WORDS);

`ifdef MICROCODE_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] csum_final;
    assign csum_final = sum_q + bus.byte_data;
`endif

    mcl_word_packer #(
        .DATA_W     (DATA_W),
        .WORD_BYTES (WORD_BYTES)
    ) u_packer (
        .clk         (clk),
        .r           (r),
        .clear_i     (start_load),
        .shift_i     (load_accept),
        .byte_i      (bus.byte_data),
        .word_o      (word),
        .word_full_o (word_full)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            MCL_IDLE, MCL_DONE, MCL_ERR: begin
                if (start) state_d = MCL_LOAD;
            end
            MCL_LOAD: begin
                // A full store rejects even the first byte of one more word.
                if (accept) begin
                    if (store_full)         state_d = MCL_ERR;
                    else if (word_full)     state_d = MCL_WRITE;
                    else if (bus.byte_last) state_d = MCL_ERR;
                end
            end
            MCL_WRITE: begin
`ifdef MICROCODE_LOADER_CHECKSUM_EN
                state_d = last_q ? MCL_CSUM : MCL_LOAD;
`else
                state_d = last_q ? MCL_DONE : MCL_LOAD;
`endif
            end
`ifdef MICROCODE_LOADER_CHECKSUM_EN
            MCL_CSUM: begin
                if (accept) state_d = (csum_final == 8'h00) ? MCL_DONE : MCL_ERR;
            end
`endif
            default: state_d = MCL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_q      <= MCL_IDLE;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_hold_q   <= 1'b0;
            last_q       <= 1'b0;
            wr_addr_q    <= '0;
            words_q      <= '0;
`ifdef MICROCODE_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            // Outputs are registered from the next state so they line up with the state they describe.
            state_q      <= state_d;
            byte_ready_q <= (state_d == MCL_LOAD) || (state_d == MCL_CSUM);
            wr_en_q      <= (state_d == MCL_WRITE);
            busy_q       <= (state_d == MCL_LOAD) || (state_d == MCL_WRITE) || (state_d == MCL_CSUM);
            done_q       <= (state_d == MCL_DONE);
            error_q      <= (state_d == MCL_ERR);
            cpu_hold_q   <= (state_d != MCL_DONE);
            if (start_load) begin
                wr_addr_q <= '0;
                words_q   <= '0;
            end else if (state_q == MCL_WRITE) begin
                wr_addr_q <= wr_addr_q + 1'b1;
                words_q   <= words_q + 1'b1;
            end
            if (load_accept && word_full) begin
                last_q <= bus.byte_last;
            end
`ifdef MICROCODE_LOADER_CHECKSUM_EN
            if (start_load) begin
                sum_q <= '0;
            end else if (load_accept) begin
                sum_q <= sum_q + bus.byte_data;
            end
`endif
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = word;
    assign cpu_hold       = cpu_hold_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign words          = words_q;
endmodule

// File: tb/tb_microcode_loader.sv
// Self-checking bench for microcode_loader: random byte images against a word-list reference model.
module tb_microcode_loader;
    import microcode_pkg::*;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [MC_ADDR_W-1:0] a;
        logic [MC_DATA_W-1:0] d;
    } wr_t;

    logic               clk = 1'b0;
    logic               r = 1'b1;
    logic               start = 1'b0;
    logic               cpu_hold, busy, done, error;
    logic [MC_ADDR_W:0] words;

    int  n_cmp = 0;
    int  n_fail = 0;
    wr_t obs_q[$];
    bit  watch = 1'b0;
    int  hold_drops = 0;

    microcode_loader_if #(.DATA_W(MC_DATA_W), .ADDR_W(MC_ADDR_W)) bus ();

    microcode_loader #(
        .DATA_W     (MC_DATA_W),
        .WORD_BYTES (MC_WORD_BYTES),
        .ADDR_W     (MC_ADDR_W)
    ) dut (
        .clk      (clk),
        .r        (r),
        .bus      (bus.slave),
        .start    (start),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .words    (words)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin : mon
        wr_t e;
        if (bus.wr_en === 1'b1) begin
            e.a = bus.wr_addr;
            e.d = bus.wr_data;
            obs_q.push_back(e);
        end
        if (watch && cpu_hold !== 1'b1 && done !== 1'b1) hold_drops++;
    end

    // Reference: microword i is bytes 8i..8i+7 read as a big-endian number.
    function automatic logic [63:0] word_of(input bq_t img, input int i);
        logic [63:0] w = 64'd0;
        for (int j = 0; j < 8; j++) w = w * 256 + 64'(img[8*i+j]);
        return w;
    endfunction

    function automatic logic [7:0] sum_of(input bq_t img);
        int s = 0;
        foreach (img[k]) s = s + int'(img[k]);
        return 8'(s % 256);
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data = 8'hEE;
        bus.byte_last = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_last = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input int gap, output bit ok);
        int t = 0;
        ok = 1'b1;
        repeat (gap) @(posedge clk);
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data = b;
        bus.byte_last = last;
        while (bus.byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL handshake: byte_ready=%b, required 1 within 50 cycles", bus.byte_ready);
            ok = 1'b0;
        end else begin
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b0;
        bus.byte_last = 1'b0;
    endtask

    task automatic load_image(input bq_t img, input bit with_last, input int gap_lo, input int gap_hi,
                              input logic [7:0] trailer, output bit ok);
        int t = 0;
        obs_q.delete();
        hold_drops = 0;
        do_start();
        watch = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < img.size() && ok; k++)
            send_byte(img[k], with_last && (k == img.size() - 1), int'($urandom_range(gap_hi, gap_lo)), ok);
`ifdef MICROCODE_LOADER_CHECKSUM_EN
        if (ok && with_last && (img.size() % 8 == 0)) send_byte(trailer, 1'($urandom_range(1, 0)), 0, ok);
`else
        if (trailer === 8'hxx) ok = 1'b0;
`endif
        while (ok && done !== 1'b1 && error !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (ok && t >= 40) begin
            n_cmp++; n_fail++;
            $display("FAIL load_end: done=%b error=%b, required one of them within 40 cycles", done, error);
            ok = 1'b0;
        end
        watch = 1'b0;
    endtask

    task automatic test_reset();
        r = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.byte_ready !== 1'b0) begin n_fail++; $display("FAIL rst_byte_ready: got %b need 0", bus.byte_ready); end
        n_cmp++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b need 0", bus.wr_en); end
        n_cmp++; if ({busy, done, error, cpu_hold} !== 4'b0000) begin n_fail++; $display("FAIL rst_status: got %b need 0000", {busy, done, error, cpu_hold}); end
        n_cmp++; if (bus.wr_addr !== '0 || bus.wr_data !== '0 || words !== '0) begin n_fail++; $display("FAIL rst_regs: got addr %h data %h words %0d need zeros", bus.wr_addr, bus.wr_data, words); end
        r = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL idle_hold: got %b need 1", cpu_hold); end
        n_cmp++; if ({busy, bus.byte_ready, done, error} !== 4'b0000) begin n_fail++; $display("FAIL idle_status: got %b need 0000", {busy, bus.byte_ready, done, error}); end
    endtask

    task automatic test_one_word();
        bit ok = 1'b1;
        int t = 0;
        obs_q.delete();
        do_start();
        for (int k = 1; k <= 8 && ok; k++) send_byte(8'(k), k == 8, 0, ok);
        n_cmp++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== '0 || bus.wr_data !== 64'h0102030405060708) begin
            n_fail++; $display("FAIL one_write: got en %b addr %h data %h need 1 000 0102030405060708", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        n_cmp++; if (busy !== 1'b1 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL one_busy: got busy %b hold %b need 1 1", busy, cpu_hold); end
`ifdef MICROCODE_LOADER_CHECKSUM_EN
        if (ok) send_byte(8'hDC, 1'b0, 0, ok);
`endif
        while (ok && done !== 1'b1 && error !== 1'b1 && t < 40) begin @(negedge clk); t++; end
        n_cmp++; if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL one_done: got done %b error %b hold %b need 1 0 0", done, error, cpu_hold); end
        n_cmp++; if (words !== 13'd1 || obs_q.size() !== 1) begin n_fail++; $display("FAIL one_count: got words %0d writes %0d need 1 1", words, obs_q.size()); end
    endtask

    task automatic test_images();
        for (int it = 0; it < 10; it++) begin
            bq_t        img;
            int         n, exp_w, bad, fi, glo, ghi;
            bit         with_last, exp_err, ok;
            logic [7:0] trailer;
            case (it)
                0:       begin n = 24; with_last = 1'b1; glo = 1; ghi = 1; end
                1:       begin n = 5;  with_last = 1'b1; glo = 0; ghi = 0; end
                2:       begin n = 8;  with_last = 1'b1; glo = 0; ghi = 0; end
                default: begin
                    n = 8 * int'($urandom_range(5, 1));
                    if ($urandom_range(2, 0) == 0) n = n - int'($urandom_range(7, 1));
                    with_last = 1'b1; glo = 0; ghi = int'($urandom_range(2, 0));
                end
            endcase
            for (int k = 0; k < n; k++) img.push_back(8'($urandom));
            trailer = 8'(0) - sum_of(img);
            if (it >= 3 && $urandom_range(3, 0) == 0) trailer = trailer + 8'($urandom_range(255, 1));
            exp_w   = n / 8;
            exp_err = (n % 8 != 0);
`ifdef MICROCODE_LOADER_CHECKSUM_EN
            if (!exp_err) exp_err = (8'(sum_of(img) + trailer) != 8'h00);
`endif
            load_image(img, with_last, glo, ghi, trailer, ok);
            bad = 0; fi = 0;
            for (int i = 0; i < obs_q.size() && i < exp_w; i++)
                if (obs_q[i].a !== MC_ADDR_W'(i) || obs_q[i].d !== word_of(img, i)) begin
                    if (bad == 0) fi = i;
                    bad++;
                end
            n_cmp++; if (obs_q.size() !== exp_w) begin n_fail++; $display("FAIL img%0d write_count: got %0d need %0d", it, obs_q.size(), exp_w); end
            n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL img%0d write_content: %0d bad, first at %0d got addr %h data %h need addr %h data %h", it, bad, fi, obs_q[fi].a, obs_q[fi].d, MC_ADDR_W'(fi), word_of(img, fi)); end
            n_cmp++; if (done !== !exp_err || error !== exp_err) begin n_fail++; $display("FAIL img%0d status: got done %b error %b need %b %b", it, done, error, !exp_err, exp_err); end
            n_cmp++; if (cpu_hold !== exp_err || busy !== 1'b0) begin n_fail++; $display("FAIL img%0d hold: got hold %b busy %b need %b 0", it, cpu_hold, busy, exp_err); end
            n_cmp++; if (words !== (MC_ADDR_W+1)'(exp_w)) begin n_fail++; $display("FAIL img%0d words: got %0d need %0d", it, words, exp_w); end
            n_cmp++; if (hold_drops != 0) begin n_fail++; $display("FAIL img%0d early_release: cpu_hold low for %0d cycles before done, need 0", it, hold_drops); end
        end
    endtask

    task automatic test_overflow();
        bq_t img;
        bit  ok;
        int  bad = 0;
        int  fi = 0;
        for (int k = 0; k < 4096 * 8 + 1; k++) img.push_back(8'($urandom));
        load_image(img, 1'b0, 0, 0, 8'h00, ok);
        for (int i = 0; i < obs_q.size() && i < 4096; i++)
            if (obs_q[i].a !== MC_ADDR_W'(i) || obs_q[i].d !== word_of(img, i)) begin
                if (bad == 0) fi = i;
                bad++;
            end
        n_cmp++; if (obs_q.size() !== 4096) begin n_fail++; $display("FAIL ovf_count: got %0d writes need 4096", obs_q.size()); end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL ovf_content: %0d bad entries, first at %0d", bad, fi); end
        n_cmp++; if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL ovf_status: got error %b done %b hold %b need 1 0 1", error, done, cpu_hold); end
        n_cmp++; if (words !== 13'd4096) begin n_fail++; $display("FAIL ovf_words: got %0d need 4096", words); end
    endtask

    task automatic test_reset_midload();
        bit ok = 1'b1;
        int ready_seen = 0;
        obs_q.delete();
        do_start();
        for (int k = 0; k < 12 && ok; k++) send_byte(8'($urandom), 1'b0, 0, ok);
        n_cmp++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL mid_first_word: got %0d writes need 1", obs_q.size()); end
        @(negedge clk);
        r = 1'b1;
        @(negedge clk);
        n_cmp++; if ({bus.byte_ready, bus.wr_en, busy, done, error, cpu_hold} !== 6'b0) begin n_fail++; $display("FAIL mid_rst_ctrl: got %b need 000000", {bus.byte_ready, bus.wr_en, busy, done, error, cpu_hold}); end
        n_cmp++; if (bus.wr_addr !== '0 || bus.wr_data !== '0 || words !== '0) begin n_fail++; $display("FAIL mid_rst_regs: got addr %h data %h words %0d need zeros", bus.wr_addr, bus.wr_data, words); end
        repeat (2) @(negedge clk);
        obs_q.delete();
        r = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data = 8'h5A;
        repeat (20) begin
            @(negedge clk);
            if (bus.byte_ready !== 1'b0) ready_seen++;
        end
        bus.byte_valid = 1'b0;
        n_cmp++; if (obs_q.size() !== 0 || ready_seen != 0) begin n_fail++; $display("FAIL mid_after: got %0d writes, ready on %0d cycles, need 0 0", obs_q.size(), ready_seen); end
        n_cmp++; if (busy !== 1'b0 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL mid_idle: got busy %b hold %b need 0 1", busy, cpu_hold); end
    endtask

`ifdef MICROCODE_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        bq_t img;
        bit  ok;
        for (int k = 1; k <= 8; k++) img.push_back(8'(k));
        load_image(img, 1'b1, 0, 0, 8'h00, ok);
        n_cmp++; if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL csum_bad: got error %b done %b hold %b need 1 0 1", error, done, cpu_hold); end
        load_image(img, 1'b1, 0, 1, 8'hDC, ok);
        n_cmp++; if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL csum_good: got done %b error %b hold %b need 1 0 0", done, error, cpu_hold); end
    endtask
`endif

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        bus.byte_last = 1'b0;
        test_reset();
        test_one_word();
        test_images();
`ifdef MICROCODE_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_midload();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_fail + 1);
        $fatal(1);
    end
endmodule
